// File: rtl/slow_clk_meter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | slow_clk_meter_pkg                                                          |
// | Shared FSM state encodings for the slow clock meter.                        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package slow_clk_meter_pkg;
    localparam logic [1:0] ST_WAIT_FIRST = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_LOST       = 2'd2;
endpackage
`default_nettype wire

// File: rtl/slow_clk_meter_sync_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sync_edge_detect                                                            |
// | Multi-flop synchroniser with registered single-cycle rise/fall strobes.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_s_d  <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_s_d;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_s_d;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule
`default_nettype wire

// File: rtl/slow_clk_meter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | slow_clk_meter                                                              |
// | Measures period/high time of a slow input, detects loss, checks frequency.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module slow_clk_meter
    import slow_clk_meter_pkg::*;
#(
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100_000_000,
    parameter int EXPECT_N    = 50_000_000,
    parameter int TOL         = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             slw_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic             freq_ok
);
    localparam logic [CNT_W-1:0]        c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic signed [CNT_W+1:0] c_EXPECT     = (CNT_W+2)'(EXPECT_N);
    localparam logic signed [CNT_W+1:0] c_TOL        = (CNT_W+2)'(TOL);

    logic                    w_rise;
    logic                    w_fall;
    logic signed [CNT_W+1:0] w_diff;
    logic signed [CNT_W+1:0] w_abs;
    logic                    w_in_tol;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_shadow;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             r_freq_ok;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (Clk),
        .rst     (Rst),
        .i_async (slw_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Tolerance check evaluates the count about to be captured as the period.
    always_comb begin
        w_diff   = $signed({2'b00, r_cnt}) - c_EXPECT;
        w_abs    = w_diff[CNT_W+1] ? -w_diff : w_diff;
        w_in_tol = (w_abs <= c_TOL);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= ST_WAIT_FIRST;
            r_cnt          <= '0;
            r_hi_shadow    <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_freq_ok      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!en) begin
                r_state   <= ST_WAIT_FIRST;
                r_cnt     <= '0;
                r_locked  <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_FIRST: begin
                        r_cnt <= '0;
                        if (w_rise) begin
                            r_state     <= ST_RUN;
                            r_cnt       <= CNT_W'(1);
                            r_hi_shadow <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (w_fall) begin
                            r_hi_shadow <= r_cnt;
                        end
                        if (w_rise) begin
                            r_period       <= r_cnt;
                            r_high_time    <= r_hi_shadow;
                            r_period_valid <= 1'b1;
                            r_locked       <= 1'b1;
                            r_freq_ok      <= w_in_tol;
                            r_cnt          <= CNT_W'(1);
                        end else if (r_cnt == c_TIMEOUT_M1) begin
                            r_state   <= ST_LOST;
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_LOST: begin
                        // The interval spanning the outage is meaningless, so restart without reporting.
                        if (w_rise) begin
                            r_state     <= ST_RUN;
                            r_timeout   <= 1'b0;
                            r_cnt       <= CNT_W'(1);
                            r_hi_shadow <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_FIRST;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign rise_pulse   = w_rise;
    assign fall_pulse   = w_fall;
    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;
    assign freq_ok      = r_freq_ok;
endmodule
`default_nettype wire

// File: tb/tb_slow_clk_meter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_slow_clk_meter                                                           |
// | Directed bench: three meters differing only in TOL share one slow input.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_slow_clk_meter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       slw = 1'b0;
    logic [2:0] rp, fp, pv, lk, to, fo;
    logic [7:0] per [3];
    logic [7:0] ht  [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit div_on  = 0;
    int dc      = 0;
    int hi_len  = 4;
    int lo_len  = 4;

    always #5 clk = ~clk;

    slow_clk_meter #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(40), .EXPECT_N(8), .TOL(0)) u_t0 (
        .Clk(clk), .Rst(rst), .en(en), .slw_in(slw), .rise_pulse(rp[0]), .fall_pulse(fp[0]),
        .period(per[0]), .high_time(ht[0]), .period_valid(pv[0]), .locked(lk[0]),
        .timeout(to[0]), .freq_ok(fo[0]));
    slow_clk_meter #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(40), .EXPECT_N(8), .TOL(1)) u_t1 (
        .Clk(clk), .Rst(rst), .en(en), .slw_in(slw), .rise_pulse(rp[1]), .fall_pulse(fp[1]),
        .period(per[1]), .high_time(ht[1]), .period_valid(pv[1]), .locked(lk[1]),
        .timeout(to[1]), .freq_ok(fo[1]));
    slow_clk_meter #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(40), .EXPECT_N(8), .TOL(2)) u_t2 (
        .Clk(clk), .Rst(rst), .en(en), .slw_in(slw), .rise_pulse(rp[2]), .fall_pulse(fp[2]),
        .period(per[2]), .high_time(ht[2]), .period_valid(pv[2]), .locked(lk[2]),
        .timeout(to[2]), .freq_ok(fo[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: divider model steps on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (div_on) begin
            dc++;
            if ((slw && dc >= hi_len) || (!slw && dc >= lo_len)) begin
                slw = ~slw;
                dc  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pv(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!pv[0] && n < 40);
        chk(tag, pv[0], 1);
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!rp[0] && n < 40);
        chk(tag, rp[0], 1);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) cyc();
        chk("rst_period", per[0], 0);
        chk("rst_high", ht[0], 0);
        chk("rst_locked", lk[0], 0);
        chk("rst_timeout", to[0], 0);
        chk("rst_freq_ok", fo[0], 0);
        chk("rst_pv", pv[0], 0);
        chk("rst_rise", rp[0], 0);

        // 1: divider N=8
        rst = 1'b0; en = 1'b1; div_on = 1; dc = 0;
        wait_rise("t1_first_rise");
        cyc();
        chk("t1_first_no_pv", pv[0], 0);
        chk("t1_first_unlocked", lk[0], 0);
        wait_pv("t1_pv");
        chk("t1_period", per[0], 8);
        chk("t1_high", ht[0], 4);
        chk("t1_freq_ok", fo[0], 1);
        chk("t1_locked", lk[0], 1);

        // 2: N=10 and N=9 against TOL 0/1/2
        hi_len = 5; lo_len = 5;
        wait_pv("t2a_pv0");
        wait_pv("t2a_pv1");
        chk("t2a_period", per[0], 10);
        chk("t2a_high", ht[0], 5);
        chk("t2a_fo_tol0", fo[0], 0);
        chk("t2a_fo_tol1", fo[1], 0);
        chk("t2a_fo_tol2", fo[2], 1);
        hi_len = 4; lo_len = 5;
        wait_pv("t2b_pv0");
        wait_pv("t2b_pv1");
        chk("t2b_period", per[0], 9);
        chk("t2b_high", ht[0], 4);
        chk("t2b_fo_tol0", fo[0], 0);
        chk("t2b_fo_tol1", fo[1], 1);
        hi_len = 4; lo_len = 4;
        wait_pv("t2c_pv0");
        wait_pv("t2c_pv1");
        chk("t2c_period", per[0], 8);

        // 3: signal loss 40 cycles after the last rise strobe, then recovery
        wait_rise("t3_last_rise");
        div_on = 0;
        repeat (39) cyc();
        chk("t3_to_early", to[0], 0);
        chk("t3_lk_early", lk[0], 1);
        cyc();
        chk("t3_timeout", to[0], 1);
        chk("t3_unlocked", lk[0], 0);
        div_on = 1; dc = 0;
        wait_rise("t3_resume_rise");
        cyc();
        chk("t3_to_clear", to[0], 0);
        chk("t3_resume_no_pv", pv[0], 0);
        wait_pv("t3_pv");
        chk("t3_period", per[0], 8);
        chk("t3_locked", lk[0], 1);

        // 4: drop enable for 3 cycles mid-period
        en = 1'b0;
        cyc();
        chk("t4_unlocked", lk[0], 0);
        chk("t4_period_hold", per[0], 8);
        chk("t4_fo_hold", fo[0], 1);
        cyc(); cyc();
        en = 1'b1;
        wait_rise("t4_rise");
        cyc();
        chk("t4_first_no_pv", pv[0], 0);
        wait_pv("t4_pv");
        chk("t4_period", per[0], 8);
        chk("t4_locked", lk[0], 1);

        // 5: one-cycle reset in the high phase
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_period", per[0], 0);
        chk("t5_high", ht[0], 0);
        chk("t5_locked", lk[0], 0);
        chk("t5_fo", fo[0], 0);
        wait_pv("t5_pv0");
        wait_pv("t5_pv1");
        chk("t5_relock", lk[0], 1);
        chk("t5_period_relock", per[0], 8);

        // 6: synchroniser latency and unsampled glitch
        div_on = 0; slw = 1'b0;
        repeat (6) cyc();
        slw = 1'b1;
        cyc(); chk("t6_rise_e0", rp[0], 0);
        cyc(); chk("t6_rise_e1", rp[0], 0);
        cyc(); chk("t6_rise_e2", rp[0], 1);
        cyc(); chk("t6_rise_e3", rp[0], 0);
        slw = 1'b0;
        cyc(); cyc(); cyc();
        chk("t6_fall_e2", fp[0], 1);
        repeat (4) cyc();
        @(posedge clk);
        #2 slw = 1'b1;
        #2 slw = 1'b0;
        seen = 0;
        repeat (6) begin
            cyc();
            if (rp[0]) seen++;
        end
        chk("t6_glitch", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
